// File: rtl/clock_enable_gen_if.sv
// Signals between the CPU clock-enable generator and its controller/CPU.
// The generator takes the slave modport; the driver of the controls takes master.
interface clock_enable_gen_if #(
   parameter int unsigned CNT_W = 16
);
   logic             slow_clk;
   logic             step_btn;
   logic [1:0]       mode;
   logic             halt_req;
   logic             resume;
   logic             cpu_en;
   logic [CNT_W-1:0] tick_count;
   logic [1:0]       state;
   logic             halted;

   modport master (
      output slow_clk, step_btn, mode, halt_req, resume,
      input  cpu_en, tick_count, state, halted
   );

   modport slave (
      input  slow_clk, step_btn, mode, halt_req, resume,
      output cpu_en, tick_count, state, halted
   );
endinterface

// File: rtl/clock_enable_gen.sv
// CPU clock-enable generator: RUN follows slow_clk rising edges, STEP follows a
// debounced push button, HALT (or a latched CPU halt) blocks all enables.
module clock_enable_gen #(
   parameter int unsigned DEBOUNCE = 16,
   parameter int unsigned CNT_W    = 16
) (
   input logic               clk,
   input logic               rst,
   clock_enable_gen_if.slave bus
);

   typedef enum logic [1:0] {
      StHalt = 2'b00,
      StRun  = 2'b01,
      StStep = 2'b10
   } state_e;

   localparam int unsigned   DbW   = 8;
   localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE);
   localparam logic [DbW-1:0] DbArm = DbW'(DEBOUNCE - 1);

   logic             slow_s1_q, slow_s2_q, slow_prev_q;
   logic             step_s1_q, step_s2_q;
   logic [1:0]       sync_vld_q;
   logic             slow_arm_q, slow_arm_d;
   logic [DbW-1:0]   db_cnt_q, db_cnt_d;
   logic             tick_q, tick_d;
   logic             step_q, step_d;
   state_e           state_q, state_d;
   logic             halted_q, halted_d;
   logic             cpu_en_q, cpu_en_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             fire;

   always_comb begin
      // A slow_clk already high at reset release must be seen low before it can tick.
      slow_arm_d = slow_arm_q | (sync_vld_q[1] & ~slow_s2_q);
      tick_d     = slow_s2_q & ~slow_prev_q & slow_arm_q & ~bus.halt_req;

      if (!step_s2_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q != DbMax) begin
         db_cnt_d = db_cnt_q + DbW'(1);
      end else begin
         db_cnt_d = db_cnt_q;
      end
      step_d = step_s2_q & (db_cnt_q == DbArm) & ~bus.halt_req;

      halted_d = bus.halt_req | (halted_q & ~bus.resume);

      state_d = StHalt;
      if (!halted_q) begin
         case (bus.mode)
            2'b01:   state_d = StRun;
            2'b10:   state_d = StStep;
            default: state_d = StHalt;
         endcase
      end

      fire = 1'b0;
      case (state_q)
         StRun:   fire = tick_q;
         StStep:  fire = step_q;
         default: fire = 1'b0;
      endcase
      // Halt wins over a same-cycle tick/step; the last term keeps pulses apart.
      cpu_en_d = fire & ~halted_q & ~bus.halt_req & ~cpu_en_q;

      count_d = count_q + CNT_W'(cpu_en_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         slow_s1_q   <= 1'b0;
         slow_s2_q   <= 1'b0;
         slow_prev_q <= 1'b0;
         step_s1_q   <= 1'b0;
         step_s2_q   <= 1'b0;
         sync_vld_q  <= 2'b00;
         slow_arm_q  <= 1'b0;
         db_cnt_q    <= '0;
         tick_q      <= 1'b0;
         step_q      <= 1'b0;
         state_q     <= StHalt;
         halted_q    <= 1'b0;
         cpu_en_q    <= 1'b0;
         count_q     <= '0;
      end else begin
         slow_s1_q   <= bus.slow_clk;
         slow_s2_q   <= slow_s1_q;
         slow_prev_q <= slow_s2_q;
         step_s1_q   <= bus.step_btn;
         step_s2_q   <= step_s1_q;
         sync_vld_q  <= {sync_vld_q[0], 1'b1};
         slow_arm_q  <= slow_arm_d;
         db_cnt_q    <= db_cnt_d;
         tick_q      <= tick_d;
         step_q      <= step_d;
         state_q     <= state_d;
         halted_q    <= halted_d;
         cpu_en_q    <= cpu_en_d;
         count_q     <= count_d;
      end
   end

   assign bus.cpu_en     = cpu_en_q;
   assign bus.tick_count = count_q;
   assign bus.state      = state_q;
   assign bus.halted     = halted_q;

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen: FSM vector table plus pulse scoreboard
// keyed on the expected cycle of every cpu_en pulse.
module tb_clock_enable_gen;

   localparam int unsigned Debounce = 16;
   localparam int unsigned CntW     = 4;

   typedef struct {
      logic [1:0] mode;
      logic       halt_req;
      logic       resume;
      logic [1:0] exp_state;
      logic       exp_halted;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc       = 0;
   int   checks    = 0;
   int   errors    = 0;
   int   exp_count = 0;
   int   mon_exp;
   int   exp_q[$];
   logic en_prev   = 1'b0;
   vec_t vecs[12];

   clock_enable_gen_if #(.CNT_W(CntW)) bus ();

   clock_enable_gen #(
      .DEBOUNCE(Debounce),
      .CNT_W   (CntW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Every cpu_en pulse must match the oldest scheduled expectation.
   always @(negedge clk) begin
      if (bus.cpu_en === 1'b1) begin
         checks++;
         if (en_prev) begin
            errors++;
            $display("FAIL cpu_en_width: high in two consecutive cycles at cycle %0d", cyc);
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cpu_en_unexpected: pulse at cycle %0d, required none", cyc);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_exp != cyc) begin
               errors++;
               $display("FAIL cpu_en_timing: pulse at cycle %0d, required cycle %0d", cyc, mon_exp);
            end
         end
      end
      en_prev = (bus.cpu_en === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_pulse(input int at);
      exp_q.push_back(at);
      exp_count++;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 80; i++) begin
         if (exp_q.size() == 0) break;
         tick(1);
      end
      tick(4);
      chk(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // slow_clk sampled high at edge N gives cpu_en after edge N+3, i.e. cyc+4 here.
   task automatic slow_rise(input bit counted);
      bus.slow_clk = 1'b1;
      if (counted) expect_pulse(cyc + 4);
      tick(5);
      bus.slow_clk = 1'b0;
      tick(5);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_cpu_en"}, bus.cpu_en, 0);
      chk({tag, "_tick_count"}, bus.tick_count, 0);
      chk({tag, "_state"}, bus.state, 0);
      chk({tag, "_halted"}, bus.halted, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{2'b01, 1'b0, 1'b0, 2'b01, 1'b0};
      vecs[1]  = '{2'b10, 1'b0, 1'b0, 2'b10, 1'b0};
      vecs[2]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
      vecs[3]  = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0};
      vecs[4]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1};
      vecs[5]  = '{2'b01, 1'b0, 1'b0, 2'b00, 1'b1};
      vecs[6]  = '{2'b10, 1'b0, 1'b1, 2'b00, 1'b0};
      vecs[7]  = '{2'b10, 1'b0, 1'b0, 2'b10, 1'b0};
      vecs[8]  = '{2'b10, 1'b1, 1'b1, 2'b10, 1'b1};
      vecs[9]  = '{2'b01, 1'b0, 1'b1, 2'b00, 1'b0};
      vecs[10] = '{2'b01, 1'b0, 1'b0, 2'b01, 1'b0};
      vecs[11] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0};

      rst          = 1'b0;
      bus.slow_clk = 1'b0;
      bus.step_btn = 1'b0;
      bus.mode     = 2'b00;
      bus.halt_req = 1'b0;
      bus.resume   = 1'b0;
      tick(3);
      chk_zero("reset");
      rst = 1'b1;
      tick(3);

      // Mode decode and halt latch, one vector per cycle.
      for (int i = 0; i < 12; i++) begin
         bus.mode     = vecs[i].mode;
         bus.halt_req = vecs[i].halt_req;
         bus.resume   = vecs[i].resume;
         tick(1);
         chk($sformatf("vec%0d_state", i), bus.state, vecs[i].exp_state);
         chk($sformatf("vec%0d_halted", i), bus.halted, vecs[i].exp_halted);
      end
      bus.halt_req = 1'b0;
      bus.resume   = 1'b0;
      tick(2);

      // RUN: five slow_clk rises, 20 clk high / 20 clk low.
      bus.mode = 2'b01;
      tick(3);
      chk("run_state", bus.state, 2'b01);
      for (int i = 0; i < 5; i++) begin
         bus.slow_clk = 1'b1;
         expect_pulse(cyc + 4);
         tick(20);
         bus.slow_clk = 1'b0;
         tick(20);
      end
      drain("run_drain");
      chk("run_tick_count", bus.tick_count, exp_count % (1 << CntW));

      // STEP: bouncing press, then a long stable press gives exactly one pulse.
      bus.mode = 2'b10;
      tick(2);
      chk("step_state", bus.state, 2'b10);
      for (int i = 0; i < 4; i++) begin
         bus.step_btn = 1'b1;
         tick(1);
         bus.step_btn = 1'b0;
         tick(1);
      end
      tick(2);
      bus.step_btn = 1'b1;
      expect_pulse(cyc + Debounce + 3);
      tick(40);
      bus.step_btn = 1'b0;
      tick(3);
      drain("step_drain");
      chk("step_tick_count", bus.tick_count, exp_count % (1 << CntW));
      slow_rise(1'b0);
      drain("step_ignores_slow");

      // Halt priority: halt_req lands in the cycle the tick would fire.
      bus.mode = 2'b01;
      tick(3);
      bus.slow_clk = 1'b1;
      tick(3);
      bus.halt_req = 1'b1;
      tick(1);
      bus.halt_req = 1'b0;
      chk("halt_set", bus.halted, 1);
      tick(1);
      chk("halt_state", bus.state, 2'b00);
      bus.slow_clk = 1'b0;
      tick(5);
      slow_rise(1'b0);
      bus.resume = 1'b1;
      tick(1);
      bus.resume = 1'b0;
      chk("resume_clear", bus.halted, 0);
      tick(1);
      chk("resume_state", bus.state, 2'b01);
      slow_rise(1'b1);
      drain("halt_drain");
      chk("halt_tick_count", bus.tick_count, exp_count % (1 << CntW));

      // Wrap: fresh reset, 17 ticks on a 4-bit counter.
      rst = 1'b0;
      tick(3);
      rst       = 1'b1;
      exp_count = 0;
      tick(1);
      chk("wrap_release_state", bus.state, 2'b01);
      chk("wrap_release_count", bus.tick_count, 0);
      tick(2);
      for (int i = 0; i < 17; i++) slow_rise(1'b1);
      drain("wrap_drain");
      chk("wrap_tick_count", bus.tick_count, exp_count % (1 << CntW));

      // Reset mid-debounce with slow_clk held high through release.
      bus.mode     = 2'b10;
      bus.slow_clk = 1'b1;
      bus.step_btn = 1'b1;
      tick(8);
      rst = 1'b0;
      tick(2);
      chk_zero("midreset");
      exp_count    = 0;
      bus.mode     = 2'b01;
      bus.step_btn = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
      chk("midreset_release_state", bus.state, 2'b01);
      tick(30);
      drain("held_high_no_tick");
      bus.slow_clk = 1'b0;
      tick(5);
      slow_rise(1'b1);
      drain("fresh_rise_drain");
      chk("fresh_rise_tick_count", bus.tick_count, exp_count % (1 << CntW));

      // Mode 11 behaves as HALT even with both sources active.
      bus.mode     = 2'b11;
      bus.step_btn = 1'b1;
      for (int i = 0; i < 4; i++) slow_rise(1'b0);
      chk("mode11_state", bus.state, 2'b00);
      bus.step_btn = 1'b0;
      drain("mode11_drain");
      chk("mode11_tick_count", bus.tick_count, exp_count % (1 << CntW));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clock_enable_gen.md
CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

Interface
REQ-001 Parameter DEBOUNCE, default 16: clk cycles step_btn must stay stable high before one step is accepted (legal range 2..255).
REQ-002 Parameter CNT_W, default 16: width of tick_count.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 rst  input  1  reset; synchronous to clk, active-low.
REQ-005 slow_clk  input  1  divided clock level from the clock divider; treated as asynchronous.
REQ-006 step_btn  input  1  manual single-step push button; asynchronous and bouncing.
REQ-007 mode  input  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
REQ-008 halt_req  input  1  one-cycle pulse from the CPU on an HLT instruction.
REQ-009 resume  input  1  one-cycle pulse that clears a latched CPU halt.
REQ-010 cpu_en  output  1  one-cycle clock-enable pulse that advances the CPU one step.
REQ-011 tick_count  output  CNT_W  number of cpu_en pulses issued, modulo 2^CNT_W.
REQ-012 state  output  2  current FSM state: 00 HALT, 01 RUN, 10 STEP.
REQ-013 halted  output  1  latched CPU-halt flag.

Function
REQ-014 slow_clk and step_btn shall each pass through a dedicated 2-flop synchronizer before any use.
REQ-015 A slow tick shall be a rising edge detected between the second synchronizer stage and a registered copy of that stage.
REQ-016 Slow-tick latency: if slow_clk is first sampled high at clk edge N, the tick shall drive a cpu_en pulse high from edge N+3 to edge N+4.
REQ-017 Debounce: a counter shall increment while synced step_btn is high, clear to 0 when it is low, and saturate at DEBOUNCE.
REQ-018 A step pulse shall occur exactly once per press, in the cycle the debounce counter reaches DEBOUNCE-1 → DEBOUNCE; no repeat until step_btn has been low for at least one synced cycle.
REQ-019 The FSM states shall be HALT, RUN and STEP, held in a registered state evaluated every clk cycle.
REQ-020 The next state shall be HALT if halted=1 or mode is 00 or 11; otherwise RUN for mode 01 and STEP for mode 10.
REQ-021 A mode change shall take effect at the next clk edge.
REQ-022 In RUN, cpu_en shall follow the slow tick; step pulses shall be ignored.
REQ-023 In STEP, cpu_en shall follow the step pulse; slow ticks shall be ignored.
REQ-024 In HALT, cpu_en shall be 0; ticks and steps arriving in HALT shall be discarded, not queued.
REQ-025 cpu_en shall be registered, never wider than one cycle, and never asserted in two consecutive cycles.
REQ-026 halt_req shall set halted at the next edge.
REQ-027 A halt_req arriving in the same cycle as a tick or step shall suppress that cpu_en, so halt wins.
REQ-028 resume shall clear halted at the next edge.
REQ-029 If halt_req and resume arrive together, halted shall be set, so halt wins.
REQ-030 tick_count shall increment by 1 on every cycle cpu_en is high, wrapping from 2^CNT_W-1 to 0 with no flag.

Reset
REQ-031 While rst=0 at a clk edge, the block shall clear: cpu_en=0, tick_count=0, state=HALT, halted=0, both synchronizers, the edge register and the debounce counter.
REQ-032 A slow_clk that is already high at reset release shall not produce a tick until it goes low and then high again.
REQ-033 A reset asserted mid-operation shall abort any pending pulse, with no cpu_en in the first cycle after release.
REQ-034 After reset release, state shall reach the mode-selected state one edge later.

Verification
REQ-035 RUN: mode=01, slow_clk toggled every 20 clk for 5 rising edges -> exactly 5 cpu_en pulses, each 3 edges after the slow_clk rise; tick_count=5.
REQ-036 STEP debounce: mode=10, step_btn bounces 4 times in 10 cycles, then stays high for 40 cycles -> exactly 1 cpu_en pulse; tick_count=1.
REQ-037 Halt priority: mode=01, halt_req in the cycle a tick would fire -> no cpu_en, halted=1, state=HALT; then resume -> RUN, and the next tick counts.
REQ-038 Wrap: CNT_W=4, 17 RUN ticks -> tick_count=1.
REQ-039 Reset: rst=0 pulsed mid-debounce with slow_clk held high -> all outputs zero, and no cpu_en until a fresh slow_clk rise.
REQ-040 Mode 11 with slow_clk and step_btn both active -> state=HALT, cpu_en stays 0.
